// File: rtl/wos_ctrl_pkg.sv
// Shared definitions for the WOS window sequencer: state encoding, default window size
// and the mask bit-index helper (bit r*MAX_N+c).
package wos_ctrl_pkg;

  localparam int MAX_N_DEFAULT = 5;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    READ,
    WAIT,
    WRITE,
    FIN,
    ERR
  } state_t;

  function automatic int mask_bit(input int r, input int c, input int max_n);
    return r * max_n + c;
  endfunction

endpackage

// File: rtl/wos_window_addr_gen.sv
// Window/output position counters and the read/write address computations (32-bit wrap).
// WOS_MASK_SKIP_EN: r/c step only through mask-selected window positions.
module wos_window_addr_gen
  import wos_ctrl_pkg::*;
#(
  parameter int MAX_N = MAX_N_DEFAULT,
  parameter int DIM_W = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     xy_clear,
  input  logic                     xy_step,
  input  logic                     rc_first,
  input  logic                     rc_step,
  input  logic [31:0]              img_base,
  input  logic [31:0]              out_base,
  input  logic [DIM_W-1:0]         img_w,
  input  logic [DIM_W-1:0]         img_h,
  input  logic [2:0]               win_n,
  input  logic [MAX_N*MAX_N-1:0]   mask,
  output logic [31:0]              rd_addr,
  output logic [31:0]              wr_addr,
  output logic                     win_last,
  output logic                     win_empty,
  output logic                     out_last
);

  logic [DIM_W-1:0] x, y, x_max, y_max, out_w;
  logic [2:0]       r, c, first_r, first_c, next_r, next_c;
  logic             first_ok, next_ok, sel;
  logic [MAX_N*MAX_N-1:0] sh;

  assign x_max = img_w - DIM_W'(win_n);
  assign y_max = img_h - DIM_W'(win_n);
  assign out_w = x_max + 1'b1;

  // Descending scan so the last hit is the lowest row-major position.
  always_comb begin
    first_ok = 1'b0;
    first_r  = '0;
    first_c  = '0;
    next_ok  = 1'b0;
    next_r   = '0;
    next_c   = '0;
    sel      = 1'b0;
    sh       = '0;
    for (int rr = MAX_N - 1; rr >= 0; rr--) begin
      for (int cc = MAX_N - 1; cc >= 0; cc--) begin
        sh = mask >> mask_bit(rr, cc, MAX_N);
`ifdef WOS_MASK_SKIP_EN
        sel = sh[0];
`else
        sel = 1'b1;
`endif
        if (rr < int'(win_n) && cc < int'(win_n) && sel) begin
          first_ok = 1'b1;
          first_r  = 3'(rr);
          first_c  = 3'(cc);
          if (rr > int'(r) || (rr == int'(r) && cc > int'(c))) begin
            next_ok = 1'b1;
            next_r  = 3'(rr);
            next_c  = 3'(cc);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x <= '0;
      y <= '0;
      r <= '0;
      c <= '0;
    end else begin
      if (xy_clear) begin
        x <= '0;
        y <= '0;
      end else if (xy_step) begin
        if (x == x_max) begin
          x <= '0;
          y <= y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end
      if (rc_first) begin
        r <= first_r;
        c <= first_c;
      end else if (rc_step) begin
        r <= next_r;
        c <= next_c;
      end
    end
  end

  assign rd_addr   = img_base + (32'(y) + 32'(r)) * 32'(img_w) + 32'(x) + 32'(c);
  assign wr_addr   = out_base + 32'(y) * 32'(out_w) + 32'(x);
  assign win_last  = !next_ok;
  assign win_empty = !first_ok;
  assign out_last  = (x == x_max) && (y == y_max);

endmodule

// File: rtl/wos_window_sequencer.sv
// Sequences one WOS pass: N x N window reads, wait for the kernel, one write per output pixel.
// Waits indefinitely on res_valid; start while busy is ignored. Mask skipping under WOS_MASK_SKIP_EN.
module wos_window_sequencer
  import wos_ctrl_pkg::*;
#(
  parameter int MAX_N = MAX_N_DEFAULT,
  parameter int DIM_W = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [31:0]            img_base,
  input  logic [31:0]            out_base,
  input  logic [DIM_W-1:0]       img_w,
  input  logic [DIM_W-1:0]       img_h,
  input  logic [2:0]             win_n,
  input  logic [MAX_N*MAX_N-1:0] mask,
  output logic [31:0]            kernel_address,
  output logic                   kernel_running,
  output logic                   kernel_w_en,
  output logic [7:0]             kernel_input,
  input  logic [7:0]             mem_rdata,
  output logic                   pix_valid,
  output logic [7:0]             pix_data,
  output logic                   pix_last,
  input  logic                   res_valid,
  input  logic [7:0]             res_data,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  state_t state, nxt;

  logic [31:0]            cfg_img_base, cfg_out_base;
  logic [DIM_W-1:0]       cfg_w, cfg_h;
  logic [2:0]             cfg_n;
  logic [MAX_N*MAX_N-1:0] cfg_mask;
  logic [7:0]             res_q;
  logic                   err_q, bad_cfg;
  logic                   xy_clear, xy_step, rc_first, rc_step;
  logic [31:0]            rd_addr, wr_addr;
  logic                   win_last, win_empty, out_last;

  wos_window_addr_gen #(.MAX_N(MAX_N), .DIM_W(DIM_W)) u_addr (
    .clk      (clk),
    .rst      (rst),
    .xy_clear (xy_clear),
    .xy_step  (xy_step),
    .rc_first (rc_first),
    .rc_step  (rc_step),
    .img_base (cfg_img_base),
    .out_base (cfg_out_base),
    .img_w    (cfg_w),
    .img_h    (cfg_h),
    .win_n    (cfg_n),
    .mask     (cfg_mask),
    .rd_addr  (rd_addr),
    .wr_addr  (wr_addr),
    .win_last (win_last),
    .win_empty(win_empty),
    .out_last (out_last)
  );

  assign bad_cfg = (cfg_n == 3'd0) || (int'(cfg_n) > MAX_N) ||
                   (cfg_w < DIM_W'(cfg_n)) || (cfg_h < DIM_W'(cfg_n));

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cfg_img_base <= '0;
      cfg_out_base <= '0;
      cfg_w        <= '0;
      cfg_h        <= '0;
      cfg_n        <= '0;
      cfg_mask     <= '0;
      res_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && start) begin
        cfg_img_base <= img_base;
        cfg_out_base <= out_base;
        cfg_w        <= img_w;
        cfg_h        <= img_h;
        cfg_n        <= win_n;
        cfg_mask     <= mask;
        err_q        <= 1'b0;
      end
      if (state == CHECK && bad_cfg) err_q <= 1'b1;
      // An empty window writes 0, so clear before any window that may skip WAIT.
      if (state == WAIT && res_valid) res_q <= res_data;
      else if (state == CHECK || state == WRITE) res_q <= '0;
    end
  end

  always_comb begin
    nxt      = state;
    xy_clear = 1'b0;
    xy_step  = 1'b0;
    rc_first = 1'b0;
    rc_step  = 1'b0;
    case (state)
      IDLE:  if (start) nxt = CHECK;
      CHECK: begin
        xy_clear = 1'b1;
        rc_first = 1'b1;
        if (bad_cfg)        nxt = ERR;
        else if (win_empty) nxt = WRITE;
        else                nxt = READ;
      end
      READ: begin
        if (win_last) nxt = WAIT;
        else          rc_step = 1'b1;
      end
      WAIT:  if (res_valid) nxt = WRITE;
      WRITE: begin
        xy_step  = 1'b1;
        rc_first = 1'b1;
        if (out_last)       nxt = FIN;
        else if (win_empty) nxt = WRITE;
        else                nxt = READ;
      end
      FIN:     nxt = IDLE;
      ERR:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // WAIT keeps showing the last read address (r/c are not advanced past it).
  always_comb begin
    kernel_address = '0;
    if (state == READ || state == WAIT) kernel_address = rd_addr;
    else if (state == WRITE)            kernel_address = wr_addr;
  end

  assign kernel_running = (state == READ) || (state == WAIT) || (state == WRITE);
  assign kernel_w_en    = (state == WRITE);
  assign kernel_input   = (state == WRITE) ? res_q : 8'h00;
  assign pix_valid      = (state == READ);
  assign pix_data       = (state == READ) ? mem_rdata : 8'h00;
  assign pix_last       = (state == READ) && win_last;
  assign busy           = (state != IDLE);
  assign done           = (state == FIN) || (state == ERR);
  assign err            = err_q;

endmodule

// File: tb/tb_wos_window_sequencer.sv
// Bench for wos_window_sequencer: byte memory model, max-of-window kernel model, table of passes
// with read/write scoreboards, plus a reset-in-WAIT sequence. Honours WOS_MASK_SKIP_EN.
module tb_wos_window_sequencer;
  import wos_ctrl_pkg::*;

  localparam int MAX_N = 5;
  localparam int DIM_W = 10;
`ifdef WOS_MASK_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] img_base, out_base;
  logic [9:0]  img_w, img_h;
  logic [2:0]  win_n;
  logic [24:0] mask;
  logic [31:0] kernel_address;
  logic        kernel_running, kernel_w_en;
  logic [7:0]  kernel_input, mem_rdata, pix_data, res_data;
  logic        pix_valid, pix_last, res_valid, busy, done, err;

  always #5 clk = ~clk;

  logic [7:0] mem [0:4095];
  assign mem_rdata = mem[kernel_address[11:0]];

  wos_window_sequencer #(.MAX_N(MAX_N), .DIM_W(DIM_W)) dut (
    .clk(clk), .rst(rst), .start(start), .img_base(img_base), .out_base(out_base),
    .img_w(img_w), .img_h(img_h), .win_n(win_n), .mask(mask),
    .kernel_address(kernel_address), .kernel_running(kernel_running),
    .kernel_w_en(kernel_w_en), .kernel_input(kernel_input), .mem_rdata(mem_rdata),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_last(pix_last),
    .res_valid(res_valid), .res_data(res_data), .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    int          w;
    int          h;
    int          n;
    logic [24:0] m;
    int          dly;
    int          poke;
    logic        exp_err;
    logic [31:0] base;
    logic [31:0] obase;
  } case_t;

  typedef struct { logic [31:0] addr; logic last; } rd_t;
  typedef struct { logic [31:0] addr; logic [7:0] data; } wr_t;

  rd_t   exp_rd[$];
  wr_t   exp_wr[$];
  case_t tbl [11];
  int    checks = 0;
  int    passed = 0;
  int    kdelay = 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Kernel model: max of the streamed pixels, answered kdelay cycles after pix_last.
  initial begin : kernel
    logic [7:0] kacc, kres;
    int kcnt;
    kacc = 8'h00; kres = 8'h00; kcnt = 0;
    res_valid = 1'b0; res_data = 8'h00;
    forever begin
      @(negedge clk);
      res_valid = 1'b0;
      if (kcnt > 0) begin
        kcnt--;
        if (kcnt == 0) begin
          res_valid = 1'b1;
          res_data  = kres;
        end
      end
      if (pix_valid) begin
        if (pix_data > kacc) kacc = pix_data;
        if (pix_last) begin
          kres = kacc;
          kacc = 8'h00;
          kcnt = kdelay;
        end
      end
    end
  end

  function automatic bit pos_sel(input logic [24:0] m, input int r, input int c);
    logic [24:0] s;
    if (!SKIP) return 1'b1;
    s = m >> mask_bit(r, c, MAX_N);
    return s[0];
  endfunction

  task automatic fill_img(input case_t t);
    for (int i = 0; i < t.w * t.h; i++)
      mem[12'(int'(t.base) + i)] = 8'((i * 53 + int'(t.base) * 7 + 11) & 255);
  endtask

  task automatic build_expect(input case_t t, output int nsel);
    int k;
    logic [7:0] mx, px;
    rd_t rd;
    wr_t wr;
    exp_rd.delete();
    exp_wr.delete();
    nsel = 0;
    if (t.exp_err) return;
    for (int r = 0; r < t.n; r++)
      for (int c = 0; c < t.n; c++)
        if (pos_sel(t.m, r, c)) nsel++;
    for (int y = 0; y <= t.h - t.n; y++) begin
      for (int x = 0; x <= t.w - t.n; x++) begin
        k = 0;
        mx = 8'h00;
        for (int r = 0; r < t.n; r++) begin
          for (int c = 0; c < t.n; c++) begin
            if (pos_sel(t.m, r, c)) begin
              rd.addr = t.base + 32'((y + r) * t.w + x + c);
              rd.last = (k == nsel - 1);
              exp_rd.push_back(rd);
              px = mem[rd.addr[11:0]];
              if (px > mx) mx = px;
              k++;
            end
          end
        end
        wr.addr = t.obase + 32'(y * (t.w - t.n + 1) + x);
        wr.data = mx;
        exp_wr.push_back(wr);
      end
    end
  endtask

  task automatic drive_cfg(input case_t t);
    img_base = t.base;
    out_base = t.obase;
    img_w    = 10'(t.w);
    img_h    = 10'(t.h);
    win_n    = 3'(t.n);
    mask     = t.m;
  endtask

  task automatic run_pass(input case_t t, input string tag);
    int cyc, busy_cyc, nsel, nwin, exp_busy;
    bit got_done, run_seen;
    logic [31:0] last_rd;
    rd_t rd;
    wr_t wr;
    if (!t.exp_err) fill_img(t);
    build_expect(t, nsel);
    nwin = t.exp_err ? 0 : (t.w - t.n + 1) * (t.h - t.n + 1);
    if (t.exp_err)      exp_busy = 2;
    else if (nsel == 0) exp_busy = nwin + 2;
    else                exp_busy = nwin * (nsel + t.dly + 1) + 2;
    kdelay = t.dly;
    @(negedge clk);
    drive_cfg(t);
    start = 1'b1;
    @(negedge clk);
    img_base = 32'hFFFF_0000; img_w = 10'd1; img_h = 10'd1; win_n = 3'd7; mask = '0;
    cyc = 0; busy_cyc = 0; got_done = 1'b0; run_seen = 1'b0; last_rd = '0;
    while (!got_done && cyc < 3000) begin
      if (busy) busy_cyc++;
      if (kernel_running) run_seen = 1'b1;
      if (pix_valid) begin
        if (exp_rd.size() == 0) chk({tag, "_unexpected_read"}, 64'(kernel_address), 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          rd = exp_rd.pop_front();
          chk({tag, "_rd_addr"}, 64'(kernel_address), 64'(rd.addr));
          chk({tag, "_pix_data"}, 64'(pix_data), 64'(mem[rd.addr[11:0]]));
          chk({tag, "_pix_last"}, 64'(pix_last), 64'(rd.last));
          last_rd = kernel_address;
        end
      end else if (kernel_running && !kernel_w_en) begin
        chk({tag, "_wait_addr_hold"}, 64'(kernel_address), 64'(last_rd));
      end
      if (kernel_w_en) begin
        if (exp_wr.size() == 0) chk({tag, "_unexpected_write"}, 64'(kernel_address), 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          wr = exp_wr.pop_front();
          chk({tag, "_wr_addr"}, 64'(kernel_address), 64'(wr.addr));
          chk({tag, "_wr_data"}, 64'(kernel_input), 64'(wr.data));
        end
        mem[kernel_address[11:0]] = kernel_input;
      end
      if (t.poke != 0 && cyc == t.poke) begin
        start = 1'b1; img_base = 32'h0; win_n = 3'd1;
      end else begin
        start = 1'b0;
      end
      if (done) got_done = 1'b1;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, 64'(got_done), 64'd1);
    chk({tag, "_busy_cycles"}, 64'(busy_cyc), 64'(exp_busy));
    chk({tag, "_err"}, 64'(err), 64'(t.exp_err));
    chk({tag, "_running_seen"}, 64'(run_seen), 64'(!t.exp_err));
    chk({tag, "_reads_left"}, 64'(exp_rd.size()), 64'd0);
    chk({tag, "_writes_left"}, 64'(exp_wr.size()), 64'd0);
    chk({tag, "_idle_after_done"}, 64'({busy, done}), 64'd0);
  endtask

  task automatic reset_mid_pass();
    case_t t;
    int cyc, wrote, waitc, late, nsel;
    wr_t wr;
    t = '{4, 4, 3, 25'h1FF_FFFF, 20, 0, 1'b0, 32'h500, 32'h600};
    fill_img(t);
    build_expect(t, nsel);
    kdelay = t.dly;
    @(negedge clk);
    drive_cfg(t);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; wrote = 0; waitc = 0;
    while (waitc < 3 && cyc < 500) begin
      if (kernel_w_en) begin
        wr = exp_wr.pop_front();
        chk("rst_first_wr_addr", 64'(kernel_address), 64'(wr.addr));
        wrote++;
      end
      if (wrote == 1 && kernel_running && !pix_valid && !kernel_w_en) waitc++;
      @(negedge clk);
      cyc++;
    end
    chk("rst_reached_wait2", 64'(waitc), 64'd3);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_addr_zero", 64'(kernel_address), 64'd0);
    chk("rst_flags_zero", 64'({kernel_running, kernel_w_en, kernel_input, pix_valid, pix_data,
                               pix_last, busy, done, err}), 64'd0);
    rst = 1'b0;
    late = 0;
    repeat (40) begin
      @(negedge clk);
      if (kernel_w_en || busy) late++;
    end
    chk("rst_no_write_after", 64'(late), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0;
    img_base = '0; out_base = '0; img_w = '0; img_h = '0; win_n = '0; mask = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;

    tbl[0]  = '{4, 4, 3, 25'h1FF_FFFF,  1, 0, 1'b0, 32'h100, 32'h200};
    tbl[1]  = '{2, 2, 1, 25'h000_0001,  1, 0, 1'b0, 32'h300, 32'h310};
    tbl[2]  = '{5, 4, 2, 25'h1FF_FFFF,  3, 0, 1'b0, 32'h320, 32'h340};
    tbl[3]  = '{8, 8, 6, 25'h1FF_FFFF,  1, 0, 1'b1, 32'h360, 32'h3F0};
    tbl[4]  = '{2, 4, 3, 25'h1FF_FFFF,  1, 0, 1'b1, 32'h360, 32'h3F0};
    tbl[5]  = '{4, 4, 0, 25'h1FF_FFFF,  1, 0, 1'b1, 32'h360, 32'h3F0};
    tbl[6]  = '{4, 4, 3, 25'h000_0040,  2, 0, 1'b0, 32'h380, 32'h3A0};
    tbl[7]  = '{3, 3, 3, 25'h000_0000,  1, 0, 1'b0, 32'h3C0, 32'h3E0};
    tbl[8]  = '{5, 5, 5, 25'h1FF_FFFF,  1, 0, 1'b0, 32'h400, 32'h420};
    tbl[9]  = '{4, 4, 3, 25'h1FF_FFFF, 50, 4, 1'b0, 32'h440, 32'h460};
    tbl[10] = '{4, 3, 2, 25'h100_0021,  1, 0, 1'b0, 32'h480, 32'h4A0};

    repeat (3) @(negedge clk);
    chk("reset_addr", 64'(kernel_address), 64'd0);
    chk("reset_flags", 64'({kernel_running, kernel_w_en, kernel_input, pix_valid, pix_data,
                            pix_last, busy, done, err}), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) run_pass(tbl[i], $sformatf("t%0d", i));
    reset_mid_pass();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
